// File: rtl/ascon_tag_unit_pkg.sv
// Shared types and defaults for the Ascon tag output/verify unit.
// The optional verify path is controlled by the ASCON_TAG_VERIFY_EN macro.
package ascon_pack;

    localparam int TAG_W_DEF  = 128;
    localparam int WORD_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_CHECK,
        ST_DONE
    } tag_state_e;

    // Index width for a word counter over n words, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ascon_tag_unit_tag_word_mux.sv
// Selects the tag word addressed by the stream index, most significant word
// first, and forms its XOR against a received word for tag comparison.
module tag_word_mux
    import ascon_pack::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic [TAG_W-1:0]                        tag_i,
    input  logic [idx_width(TAG_W/WORD_W)-1:0]      idx_i,
    input  logic [WORD_W-1:0]                       cmp_i,
    output logic [WORD_W-1:0]                       word_o,
    output logic [WORD_W-1:0]                       diff_o
);

    localparam int NWORDS = TAG_W / WORD_W;
    localparam int IDX_W  = idx_width(NWORDS);

    // Index 0 addresses the top word of the tag, so word i sits at NWORDS-1-idx
    always_comb begin
        word_o = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx_i == IDX_W'(NWORDS - 1 - i)) begin
                word_o = tag_i[i*WORD_W +: WORD_W];
            end
        end
    end

    assign diff_o = word_o ^ cmp_i;

endmodule

// File: rtl/ascon_tag_unit.sv
// Ascon tag unit: captures the finalisation tag and either streams it out
// word by word (encrypt) or compares it in constant time against a received
// tag (decrypt). Verification exists only when ASCON_TAG_VERIFY_EN is defined;
// otherwise every request streams and exp_ready/tag_ok are tied low.
module ascon_tag_unit
    import ascon_pack::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_tag,
    input  logic              mode,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [WORD_W-1:0] exp_word,
    output logic              busy,
    output logic              done,
    output logic              tag_ok
);

    localparam int NWORDS = TAG_W / WORD_W;
    localparam int IDX_W  = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    generate
        if ((TAG_W % WORD_W) != 0) begin : g_bad_width
            $error("ascon_tag_unit: TAG_W must be a multiple of WORD_W");
        end
    endgenerate

    tag_state_e         state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  sel_word;
    logic [WORD_W-1:0]  word_diff;

    tag_word_mux #(.TAG_W(TAG_W), .WORD_W(WORD_W)) u_mux (
        .tag_i  (tag_q),
        .idx_i  (idx_q),
        .cmp_i  (exp_word),
        .word_o (sel_word),
        .diff_o (word_diff)
    );

    assign out_word = sel_word;
    assign busy     = (state_q != ST_IDLE);

`ifdef ASCON_TAG_VERIFY_EN
    logic [WORD_W-1:0]  diff_q, diff_d;
    logic               tag_ok_q, tag_ok_d;
    logic [WORD_W-1:0]  diff_acc;

    assign diff_acc = diff_q | word_diff;
    assign tag_ok   = tag_ok_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{mode, exp_valid, word_diff};
    assign tag_ok        = 1'b0;
`endif

    // State register; reset wipes the stored tag and aborts any transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
`ifdef ASCON_TAG_VERIFY_EN
            diff_q   <= '0;
            tag_ok_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            idx_q    <= idx_d;
`ifdef ASCON_TAG_VERIFY_EN
            diff_q   <= diff_d;
            tag_ok_q <= tag_ok_d;
`endif
        end
    end

    // Next-state and handshake logic; the last word always leads to DONE,
    // and DONE entry zeroises the secret tag and the difference accumulator
    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        out_valid = 1'b0;
        exp_ready = 1'b0;
        done      = 1'b0;
`ifdef ASCON_TAG_VERIFY_EN
        diff_d    = diff_q;
        tag_ok_d  = tag_ok_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_tag) begin
                    tag_d = tag_i;
                    idx_d = '0;
`ifdef ASCON_TAG_VERIFY_EN
                    diff_d   = '0;
                    tag_ok_d = 1'b0;
                    state_d  = mode ? ST_CHECK : ST_STREAM;
`else
                    state_d  = ST_STREAM;
`endif
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        tag_d   = '0;
                        idx_d   = '0;
`ifdef ASCON_TAG_VERIFY_EN
                        diff_d   = '0;
                        tag_ok_d = 1'b0;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef ASCON_TAG_VERIFY_EN
            ST_CHECK: begin
                exp_ready = 1'b1;
                if (exp_valid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_DONE;
                        tag_d    = '0;
                        idx_d    = '0;
                        diff_d   = '0;
                        tag_ok_d = (diff_acc == '0);
                    end else begin
                        diff_d = diff_acc;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_tag_unit.sv
// Directed bench for ascon_tag_unit: streaming, backpressure, ignored
// requests, reset abort, and either verify or the stream-only build
// depending on ASCON_TAG_VERIFY_EN.
module tb_ascon_tag_unit;

    localparam logic [127:0] TAG   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] ONES  = {128{1'b1}};

    logic          clk = 1'b0;
    logic          reset;
    logic          en_tag;
    logic          mode;
    logic [127:0]  tag_i;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_word;
    logic          exp_valid;
    logic          exp_ready;
    logic [31:0]   exp_word;
    logic          busy;
    logic          done;
    logic          tag_ok;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] words [4];

    always #5 clk = ~clk;

    ascon_tag_unit #(.TAG_W(128), .WORD_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .en_tag    (en_tag),
        .mode      (mode),
        .tag_i     (tag_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .exp_valid (exp_valid),
        .exp_ready (exp_ready),
        .exp_word  (exp_word),
        .busy      (busy),
        .done      (done),
        .tag_ok    (tag_ok)
    );

`ifndef ASCON_TAG_VERIFY_EN
    logic          en64;
    logic          mode64;
    logic          outValid64;
    logic [63:0]   outWord64;
    logic          expReady64;
    logic          busy64;
    logic          done64;
    logic          tagOk64;

    ascon_tag_unit #(.TAG_W(128), .WORD_W(64)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .en_tag    (en64),
        .mode      (mode64),
        .tag_i     (tag_i),
        .out_valid (outValid64),
        .out_ready (1'b1),
        .out_word  (outWord64),
        .exp_valid (1'b1),
        .exp_ready (expReady64),
        .exp_word  (64'h0),
        .busy      (busy64),
        .done      (done64),
        .tag_ok    (tagOk64)
    );
`endif

    // Advance one clock and settle just after the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        words[0] = 32'h00112233;
        words[1] = 32'h44556677;
        words[2] = 32'h8899AABB;
        words[3] = 32'hCCDDEEFF;
        reset = 1'b1; en_tag = 1'b0; mode = 1'b0; tag_i = TAG;
        out_ready = 1'b1; exp_valid = 1'b0; exp_word = '0;
`ifndef ASCON_TAG_VERIFY_EN
        en64 = 1'b0; mode64 = 1'b0;
`endif
        // Reset with en_tag asserted must still land in IDLE
        applyStimulus();
        en_tag = 1'b1;
        applyStimulus();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_expready", exp_ready, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_tagok", tag_ok, 0);
        checkOutput("reset_tagreg", dut.tag_q, 0);
        en_tag = 1'b0; reset = 1'b0;
        applyStimulus();

        $display("[TB] encrypt stream");
        en_tag = 1'b1; mode = 1'b0;
        applyStimulus();
        en_tag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("enc_valid%0d", i), out_valid, 1);
            checkOutput($sformatf("enc_word%0d", i), out_word, words[i]);
            checkOutput($sformatf("enc_nodone%0d", i), done, 0);
            applyStimulus();
        end
        checkOutput("enc_done", done, 1);
        checkOutput("enc_valid_off", out_valid, 0);
        checkOutput("enc_tagok", tag_ok, 0);
        applyStimulus();
        checkOutput("enc_done_pulse", done, 0);
        checkOutput("enc_idle", busy, 0);

        $display("[TB] backpressure");
        en_tag = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        checkOutput("bp_word0", out_word, words[0]);
        applyStimulus();
        checkOutput("bp_word1", out_word, words[1]);
        applyStimulus();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp_hold_word%0d", i), out_word, words[2]);
            checkOutput($sformatf("bp_hold_valid%0d", i), out_valid, 1);
            applyStimulus();
        end
        checkOutput("bp_after_word", out_word, words[2]);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_word3", out_word, words[3]);
        checkOutput("bp_nodone", done, 0);
        applyStimulus();
        checkOutput("bp_done", done, 1);
        applyStimulus();

        $display("[TB] en_tag during stream");
        en_tag = 1'b1;
        applyStimulus();
        tag_i = ONES;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) en_tag = 1'b0;
            checkOutput($sformatf("ign_word%0d", i), out_word, words[i]);
            applyStimulus();
        end
        checkOutput("ign_done", done, 1);
        checkOutput("ign_zeroised", dut.tag_q, 0);
        applyStimulus();
        checkOutput("ign_idle", busy, 0);
        tag_i = TAG;

        $display("[TB] reset mid-stream");
        en_tag = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_word2_shown", out_word, words[2]);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_done", done, 0);
        applyStimulus();
        checkOutput("rst_nodone_later", done, 0);
        en_tag = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        checkOutput("rst_restart_word0", out_word, words[0]);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("rst_restart_done", done, 1);
        applyStimulus();

`ifdef ASCON_TAG_VERIFY_EN
        $display("[TB] verify match");
        en_tag = 1'b1; mode = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        checkOutput("vm_expready", exp_ready, 1);
        checkOutput("vm_outvalid", out_valid, 0);
        exp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_word = words[i];
            applyStimulus();
        end
        exp_valid = 1'b0;
        checkOutput("vm_done", done, 1);
        checkOutput("vm_tagok", tag_ok, 1);
        applyStimulus();
        checkOutput("vm_tagok_hold", tag_ok, 1);
        checkOutput("vm_done_pulse", done, 0);

        $display("[TB] verify mismatch");
        en_tag = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        checkOutput("vx_tagok_cleared", tag_ok, 0);
        exp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_word = (i == 0) ? 32'h00112234 : words[i];
            checkOutput($sformatf("vx_expready%0d", i), exp_ready, 1);
            checkOutput($sformatf("vx_nodone%0d", i), done, 0);
            applyStimulus();
        end
        exp_valid = 1'b0;
        checkOutput("vx_done", done, 1);
        checkOutput("vx_tagok", tag_ok, 0);
        applyStimulus();
        mode = 1'b0;
`else
        $display("[TB] stream-only build, mode ignored");
        en_tag = 1'b1; mode = 1'b1;
        applyStimulus();
        en_tag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("so_word%0d", i), out_word, words[i]);
            checkOutput($sformatf("so_expready%0d", i), exp_ready, 0);
            applyStimulus();
        end
        checkOutput("so_done", done, 1);
        checkOutput("so_tagok", tag_ok, 0);
        applyStimulus();

        $display("[TB] 64-bit words, stream-only build");
        en64 = 1'b1; mode64 = 1'b1;
        applyStimulus();
        en64 = 1'b0;
        checkOutput("w64_valid0", outValid64, 1);
        checkOutput("w64_word0", outWord64, 64'h00112233_44556677);
        checkOutput("w64_expready0", expReady64, 0);
        applyStimulus();
        checkOutput("w64_word1", outWord64, 64'h8899AABB_CCDDEEFF);
        checkOutput("w64_expready1", expReady64, 0);
        applyStimulus();
        checkOutput("w64_done", done64, 1);
        checkOutput("w64_tagok", tagOk64, 0);
        checkOutput("w64_expready2", expReady64, 0);
        applyStimulus();
        checkOutput("w64_idle", busy64, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/ascon_tag_unit.md
ASCON_TAG_UNIT -- requirements
Module: ascon_tag_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 128, tag width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, stream word width; TAG_W mod WORD_W SHALL be 0 (elaboration error otherwise); NWORDS = TAG_W/WORD_W.
REQ-003 SHALL have ports:
  clk        in   1       single clock, rising edge
  reset      in   1       synchronous, active-high reset
  en_tag     in   1       capture request for tag_i
  mode       in   1       0 = encrypt (stream tag out), 1 = decrypt (verify); sampled with en_tag
  tag_i      in   TAG_W   computed tag from finalisation
  out_valid  out  1       out_word valid
  out_ready  in   1       sink accepts out_word
  out_word   out  WORD_W  tag word, MS word first
  exp_valid  in   1       expected-tag word valid
  exp_ready  out  1       block accepts exp_word
  exp_word   in   WORD_W  received tag word, MS word first
  busy       out  1       state != IDLE
  done       out  1       one-cycle completion pulse
  tag_ok     out  1       verify result

Function
REQ-004 SHALL implement FSM IDLE, STREAM, CHECK, DONE.
REQ-005 IDLE & en_tag: SHALL latch tag_i, clear word index to 0, clear diff accumulator; go STREAM if mode=0, CHECK if mode=1, next cycle.
REQ-006 en_tag outside IDLE SHALL be ignored (no recapture, no state change).
REQ-007 STREAM: out_valid=1, out_word = stored word[NWORDS-1-idx]; word and valid SHALL stay stable until out_valid & out_ready.
REQ-008 CHECK: exp_ready=1; on exp_valid & exp_ready, diff |= (exp_word XOR stored word[NWORDS-1-idx]).
REQ-009 Each handshake SHALL increment idx; handshake on idx = NWORDS-1 SHALL go DONE; no early exit on mismatch (constant time).
REQ-010 DONE: done=1 for exactly one cycle, then IDLE; same cycle tag_ok = 1 if mode=1 and diff == 0, else 0.
REQ-011 tag_ok SHALL hold its value until next accepted en_tag (cleared to 0 at capture) or reset.
REQ-012 Entering DONE SHALL zeroise the stored tag register and diff accumulator.
REQ-013 Latency: en_tag at cycle N -> out_valid or exp_ready at N+1; minimum en_tag-to-done = NWORDS+1 cycles with ready/valid held high.
REQ-014 out_valid SHALL be 0 outside STREAM; exp_ready SHALL be 0 outside CHECK.

Reset
REQ-015 reset=1 at a clock edge SHALL force IDLE, stored tag = 0, idx = 0, diff = 0, tag_ok = 0, done = 0, out_valid = 0, exp_ready = 0, busy = 0, regardless of en_tag.
REQ-016 reset mid-STREAM/CHECK SHALL abort without asserting done.

Configuration
REQ-017 Macro ASCON_TAG_VERIFY_EN defined: full behaviour above.
REQ-018 Macro undefined: mode ignored (always STREAM), CHECK state and diff logic absent, exp_ready and tag_ok tied 0.

Structure
REQ-019 FSM state enum type SHALL live in ascon_pack; TAG_W/WORD_W defaults as package constants.
REQ-020 Word selection/compare SHALL be a sub-module tag_word_mux (stored tag, idx -> word).

Verification
REQ-021 Encrypt: TAG_W=128, WORD_W=32, tag_i=0x00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 -> words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF on 4 consecutive cycles, done at cycle 5, tag_ok=0.
REQ-022 Backpressure: same tag, out_ready low 3 cycles on word 2 -> out_word=0x8899AABB held stable, no word lost or duplicated.
REQ-023 Verify match: mode=1, exp words equal tag -> done pulse, tag_ok=1; exp word 0 wrong (0x00112234) -> all 4 words still consumed, tag_ok=0.
REQ-024 en_tag with tag_i=0xFFFF...F during STREAM -> ignored, original words streamed; after done internal tag reads 0.
REQ-025 reset asserted after 2nd word -> next cycle IDLE, busy=0, no done; fresh en_tag restarts at word 0.
REQ-026 WORD_W=64 and macro undefined: mode=1 -> behaves as stream, 2 words, exp_ready never 1.
